gray_counter_ud: RTL and testbench

Parametrised up/down Gray-code counter with enable, parallel Gray load, wrap/saturate mode and a registered terminal-count flag. Successor to the fixed 4-bit up-only Gray counter. Source of Gray-coded pointers and step sequencers that cross clock domains: the Gray output changes by exactly one bit per step. Also exposes the matching binary count for local arithmetic.

---
 rtl/gray_pkg.sv | 80 ++++++++
 rtl/gray_counter_ud_gray2bin.sv | 29 ++
 rtl/gray_counter_ud.sv | 164 ++++++++++++++++
 tb/tb_gray_counter_ud.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// ---------------------------------------------------------------------------
// gray_pkg
//
// Shared helpers for Gray-coded counters and pointers.
//
// Contents:
//    GRAY_MIN_WIDTH / GRAY_MAX_WIDTH  legal counter width range
//    grayOp_t                         per-edge operation selected by a counter
//    bin2gray(b, width)               binary -> Gray, masked to width bits
//    gray2bin(g, width)               Gray -> binary, masked to width bits
//    grayParamsOk(width, resetVal)    elaboration-time parameter range check
//
// The functions work on GRAY_MAX_WIDTH-bit vectors and take the live width
// as an argument. This lets one package serve every instance width; callers
// zero-extend their operands and slice the low bits of the result.
// ---------------------------------------------------------------------------
package gray_pkg;

   localparam int GRAY_MIN_WIDTH = 2;
   localparam int GRAY_MAX_WIDTH = 16;

   // Operation the counter performs on the coming edge, already prioritised
   // (load beats step, step beats hold). Reset is handled separately because
   // it always wins.
   typedef enum logic [1:0] {
      OP_HOLD = 2'd0,
      OP_UP   = 2'd1,
      OP_DOWN = 2'd2,
      OP_LOAD = 2'd3
   } grayOp_t;

   // Binary to Gray. Bits above 'width' are forced to zero so a caller that
   // passes a dirty upper half still gets a clean code.
   function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(
      input logic [GRAY_MAX_WIDTH-1:0] b,
      input int                        width
   );
      logic [GRAY_MAX_WIDTH-1:0] masked;
      masked = '0;
      for (int i = 0; i < GRAY_MAX_WIDTH; i++) begin
         if (i < width) begin
            masked[i] = b[i];
         end
      end
      return masked ^ (masked >> 1);
   endfunction

   // Gray to binary. Each binary bit is the XOR of all Gray bits at and above
   // it, so we walk down from the top keeping a running parity.
   function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(
      input logic [GRAY_MAX_WIDTH-1:0] g,
      input int                        width
   );
      logic [GRAY_MAX_WIDTH-1:0] result;
      logic                      parity;
      result = '0;
      parity = 1'b0;
      for (int i = GRAY_MAX_WIDTH - 1; i >= 0; i--) begin
         if (i < width) begin
            parity    = parity ^ g[i];
            result[i] = parity;
         end
      end
      return result;
   endfunction

   // True when a width / reset value pair is something the Gray blocks can
   // build. Future FIFO pointer blocks share this so the limits stay aligned.
   function automatic bit grayParamsOk(input int width, input int resetVal);
      bit ok;
      ok = 1'b1;
      if (width < GRAY_MIN_WIDTH || width > GRAY_MAX_WIDTH) begin
         ok = 1'b0;
      end else if (resetVal < 0 || resetVal >= (1 << width)) begin
         ok = 1'b0;
      end
      return ok;
   endfunction

endpackage : gray_pkg

// File: rtl/gray_counter_ud_gray2bin.sv
// ---------------------------------------------------------------------------
// gray2bin_comb
//
// Purely combinational Gray-to-binary converter of parameterised width.
// Used by gray_counter_ud on its load path, and intended for reuse on the
// receiving side of a clock-domain crossing to decode synchronised pointers.
//
// Ports:
//    i_gray  in   WIDTH  Gray-coded value
//    o_bin   out  WIDTH  binary equivalent
//
// Each output bit is the reduction XOR of the Gray bits from the MSB down to
// that position. Writing it per bit (rather than as a ripple that reads
// o_bin[i+1]) keeps every bit an independent cone, so the tools see no
// self-referencing vector.
// ---------------------------------------------------------------------------
module gray2bin_comb #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] i_gray,
   output logic [WIDTH-1:0] o_bin
);

   // Prefix-XOR from the MSB down to each bit position
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign o_bin[i] = ^i_gray[WIDTH-1:i];
   end

endmodule : gray2bin_comb

// File: rtl/gray_counter_ud.sv
// ---------------------------------------------------------------------------
// gray_counter_ud
//
// Parameterised up/down Gray-code counter with step enable, parallel Gray
// load, wrap or saturate behaviour at the ends, and a registered
// terminal-count pulse. The Gray output moves by exactly one bit per step
// (including across the wrap), which makes it safe to hand to another clock
// domain; the matching binary count is exported for local arithmetic.
//
// Parameters:
//    WIDTH      counter width, 2..16
//    WRAP       1 = wrap at the ends, 0 = saturate at the ends
//    RESET_VAL  binary value taken on reset
//
// Ports:
//    clk         in   1      rising-edge clock
//    reset       in   1      synchronous, active-high reset
//    en          in   1      step enable
//    up          in   1      direction, 1 = increment (only looked at with en)
//    load        in   1      parallel load strobe, beats en
//    load_gray   in   WIDTH  Gray-coded load value
//    count_gray  out  WIDTH  registered Gray count
//    count_bin   out  WIDTH  registered binary count, always matches count_gray
//    tc          out  1      registered terminal-count pulse
//
// Both count outputs are registered from the same next-state value, so they
// change on the same edge and never disagree. No input reaches an output
// without passing through a register.
// ---------------------------------------------------------------------------
module gray_counter_ud
   import gray_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int WRAP      = 1,
   parameter int RESET_VAL = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_gray,
   output logic [WIDTH-1:0] count_gray,
   output logic [WIDTH-1:0] count_bin,
   output logic             tc
);

   // Constants derived from the parameters. The reset Gray code comes from
   // the shared package helper so it matches what FIFO pointer blocks use.
   localparam logic [WIDTH-1:0]          MAX_BIN      = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0]          ZERO_BIN     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]          ONE_BIN      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0]          RESET_BIN    = WIDTH'(RESET_VAL);
   localparam logic [GRAY_MAX_WIDTH-1:0] RESET_GRAY_X =
      bin2gray(GRAY_MAX_WIDTH'(RESET_VAL), WIDTH);
   localparam logic [WIDTH-1:0]          RESET_GRAY   = RESET_GRAY_X[WIDTH-1:0];
   localparam bit                        WRAP_EN      = (WRAP != 0);

   // Refuse to build with an out-of-range width or reset value
   if (!grayParamsOk(WIDTH, RESET_VAL)) begin : g_badParams
      $error("gray_counter_ud: WIDTH must be 2..16 and RESET_VAL < 2**WIDTH");
   end

   logic [WIDTH-1:0] r_bin;
   logic [WIDTH-1:0] r_gray;
   logic             r_tc;

   grayOp_t          w_op;
   logic [WIDTH-1:0] w_loadBin;
   logic             w_atMax;
   logic             w_atZero;
   logic [WIDTH-1:0] w_nextBin;
   logic [WIDTH-1:0] w_nextGray;
   logic             w_nextTc;

   // The load value arrives Gray-coded; decode it so the binary register can
   // be written in the same cycle as the Gray register.
   gray2bin_comb #(
      .WIDTH (WIDTH)
   ) u_loadDecode (
      .i_gray (load_gray),
      .o_bin  (w_loadBin)
   );

   // Boundary detection on the current count, before the step is applied.
   // There is no carry bit, so this is how a wrap or saturation is noticed.
   assign w_atMax  = (r_bin == MAX_BIN);
   assign w_atZero = (r_bin == ZERO_BIN);

   // Reduce the control inputs to a single prioritised operation. 'up' only
   // matters when a step is actually going to happen.
   always_comb begin
      w_op = OP_HOLD;
      if (load) begin
         w_op = OP_LOAD;
      end else if (en) begin
         w_op = up ? OP_UP : OP_DOWN;
      end
   end

   // Next-state logic for the binary count and the terminal-count pulse.
   // A step attempted at the boundary in the current direction always raises
   // tc; WRAP only decides whether the count rolls over or stays put.
   always_comb begin
      w_nextBin = r_bin;
      w_nextTc  = 1'b0;
      unique case (w_op)
         OP_LOAD: begin
            w_nextBin = w_loadBin;
         end
         OP_UP: begin
            if (w_atMax) begin
               w_nextTc = 1'b1;
               if (WRAP_EN) begin
                  w_nextBin = ZERO_BIN;
               end
            end else begin
               w_nextBin = r_bin + ONE_BIN;
            end
         end
         OP_DOWN: begin
            if (w_atZero) begin
               w_nextTc = 1'b1;
               if (WRAP_EN) begin
                  w_nextBin = MAX_BIN;
               end
            end else begin
               w_nextBin = r_bin - ONE_BIN;
            end
         end
         default: begin
            w_nextBin = r_bin;
         end
      endcase
   end

   // Gray next state. On a load the Gray input is taken verbatim (it is
   // already the encoding of w_loadBin); otherwise it is re-encoded from the
   // next binary value, which leaves it unchanged on a hold or saturation.
   always_comb begin
      w_nextGray = w_nextBin ^ (w_nextBin >> 1);
      if (w_op == OP_LOAD) begin
         w_nextGray = load_gray;
      end
   end

   // State registers. Reset wins over load and step on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin  <= RESET_BIN;
         r_gray <= RESET_GRAY;
         r_tc   <= 1'b0;
      end else begin
         r_bin  <= w_nextBin;
         r_gray <= w_nextGray;
         r_tc   <= w_nextTc;
      end
   end

   assign count_bin  = r_bin;
   assign count_gray = r_gray;
   assign tc         = r_tc;

endmodule : gray_counter_ud

// File: tb/tb_gray_counter_ud.sv
// ---------------------------------------------------------------------------
// tb_gray_counter_ud
//
// Directed bench for gray_counter_ud. Two 4-bit instances share the same
// stimulus: dutW wraps (RESET_VAL=0) and dutS saturates (RESET_VAL=5, whose
// Gray code is 7). Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_gray_counter_ud;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] loadGray;

   logic [3:0] wGray;
   logic [3:0] wBin;
   logic       wTc;
   logic [3:0] sGray;
   logic [3:0] sBin;
   logic       sTc;

   int         errors = 0;
   int         checks = 0;

   // Wrapping instance
   gray_counter_ud #(
      .WIDTH     (4),
      .WRAP      (1),
      .RESET_VAL (0)
   ) dutW (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_gray  (loadGray),
      .count_gray (wGray),
      .count_bin  (wBin),
      .tc         (wTc)
   );

   // Saturating instance with a non-zero reset value
   gray_counter_ud #(
      .WIDTH     (4),
      .WRAP      (0),
      .RESET_VAL (5)
   ) dutS (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .up         (up),
      .load       (load),
      .load_gray  (loadGray),
      .count_gray (sGray),
      .count_bin  (sBin),
      .tc         (sTc)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drive one cycle of inputs, then wait until just after the next rising
   // edge so the registered outputs can be sampled safely.
   task automatic applyStimulus(
      input logic       iReset,
      input logic       iEn,
      input logic       iUp,
      input logic       iLoad,
      input logic [3:0] iLoadGray
   );
      reset    = iReset;
      en       = iEn;
      up       = iUp;
      load     = iLoad;
      loadGray = iLoadGray;
      @(posedge clk);
      #1;
   endtask

   // Compare one instance's outputs against hand-computed values
   task automatic checkOutput(
      input string      tag,
      input logic [3:0] obsGray,
      input logic [3:0] obsBin,
      input logic       obsTc,
      input logic [3:0] expGray,
      input logic [3:0] expBin,
      input logic       expTc
   );
      checks++;
      assert (obsGray === expGray) else begin
         errors++;
         $error("[TB] FAIL %s gray: got %h expected %h", tag, obsGray, expGray);
      end
      checks++;
      assert (obsBin === expBin) else begin
         errors++;
         $error("[TB] FAIL %s bin: got %h expected %h", tag, obsBin, expBin);
      end
      checks++;
      assert (obsTc === expTc) else begin
         errors++;
         $error("[TB] FAIL %s tc: got %b expected %b", tag, obsTc, expTc);
      end
   endtask

   initial begin
      logic [3:0] grayWalk [17];
      logic [3:0] prevGray;
      logic [3:0] diffBits;

      grayWalk = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                   4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0, 4'h1};

      reset    = 1'b0;
      en       = 1'b0;
      up       = 1'b0;
      load     = 1'b0;
      loadGray = 4'h0;

      // Reset values of both instances
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      checkOutput("resetW", wGray, wBin, wTc, 4'h0, 4'h0, 1'b0);
      checkOutput("resetS", sGray, sBin, sTc, 4'h7, 4'h5, 1'b0);

      // Count up 17 steps through the whole Gray sequence and past the wrap
      prevGray = 4'h0;
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
         checkOutput($sformatf("upWalk%0d", i), wGray, wBin, wTc,
                     grayWalk[i], 4'(i + 1), (i == 15));
         diffBits = prevGray ^ wGray;
         checks++;
         assert ($countones(diffBits) === 1) else begin
            errors++;
            $error("[TB] FAIL oneBit%0d: got %0d bits changed expected 1",
                   i, $countones(diffBits));
         end
         prevGray = wGray;
      end

      // Down from reset wraps to max with tc, a hold clears tc, then E/9
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("downWrap", wGray, wBin, wTc, 4'h8, 4'hF, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
      checkOutput("holdAfterWrap", wGray, wBin, wTc, 4'h8, 4'hF, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("downAfterWrap", wGray, wBin, wTc, 4'h9, 4'hE, 1'b0);

      // Load max (Gray 8) with en=1: load wins, tc low
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h8);
      checkOutput("loadMaxS", sGray, sBin, sTc, 4'h8, 4'hF, 1'b0);
      checkOutput("loadMaxW", wGray, wBin, wTc, 4'h8, 4'hF, 1'b0);

      // Up at max: wrap instance rolls to 0, saturating instance holds F/8
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("wrapAfterLoad", wGray, wBin, wTc, 4'h0, 4'h0, 1'b1);
      checkOutput("sat1", sGray, sBin, sTc, 4'h8, 4'hF, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("sat2", sGray, sBin, sTc, 4'h8, 4'hF, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("sat3", sGray, sBin, sTc, 4'h8, 4'hF, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("satReverse", sGray, sBin, sTc, 4'h9, 4'hE, 1'b0);

      // Saturating instance at zero going down
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("satZero", sGray, sBin, sTc, 4'h0, 4'h0, 1'b1);

      // Load Gray D while en=1, then step up
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'hD);
      checkOutput("loadD", wGray, wBin, wTc, 4'hD, 4'h9, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("upAfterLoadD", wGray, wBin, wTc, 4'hF, 4'hA, 1'b0);

      // Reach count 7 (Gray 4), then reset together with load and en
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h4);
      checkOutput("load7", wGray, wBin, wTc, 4'h4, 4'h7, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'hD);
      checkOutput("resetWinsW", wGray, wBin, wTc, 4'h0, 4'h0, 1'b0);
      checkOutput("resetWinsS", sGray, sBin, sTc, 4'h7, 4'h5, 1'b0);

      // Load count 5 (Gray 7), then hold for five cycles while toggling up
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h7);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b0, i[0], 1'b0, 4'h0);
         checkOutput($sformatf("hold%0d", i), wGray, wBin, wTc, 4'h7, 4'h5, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_gray_counter_ud
